// File: rtl/scu_sequencer.sv
// Fetch/issue sequencer ahead of the SCU: walks the instruction ROM, latches each word onto D,
// pulses Run, and waits for Done. A watchdog catches a missing Done.
module scu_sequencer #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PROG_LEN = 16,
    parameter logic [3:0]  HALT_OP  = 4'hF,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              Pclk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] D,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [7:0]        instr_count
);

    localparam int unsigned       WdogW    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PROG_LEN - 1);
    localparam logic [WdogW-1:0]  WdogLast = WdogW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWaitDone,
        StHalted,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              run_q, run_d;
    logic [7:0]        count_q, count_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;
    logic              stop_q, stop_d;
    logic              done_ok;

    // Run is high only in the first WAIT_DONE cycle, so it doubles as the "ignore Done" flag.
    assign done_ok = (state_q == StWaitDone) && !run_q && Done;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        d_d     = d_q;
        run_d   = 1'b0;
        count_d = count_q;
        wdog_d  = wdog_q;
        stop_d  = stop_q;

        case (state_q)
            StIdle, StHalted, StError: begin
                if (Start) begin
                    state_d = StLoad;
                    pc_d    = '0;
                    count_d = '0;
                    wdog_d  = '0;
                    stop_d  = 1'b0;
                end
            end
            StLoad: begin
                if (Stop) begin
                    state_d = StIdle;
                    stop_d  = 1'b0;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (Stop) begin
                    state_d = StIdle;
                    stop_d  = 1'b0;
                end else if (rom_data[DATA_W-1 -: 4] == HALT_OP) begin
                    state_d = StHalted;
                    d_d     = rom_data;
                end else begin
                    state_d = StWaitDone;
                    d_d     = rom_data;
                    run_d   = 1'b1;
                    wdog_d  = '0;
                end
            end
            StWaitDone: begin
                if (Stop) begin
                    stop_d = 1'b1;
                end
                if (done_ok) begin
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                    if (pc_q == LastAddr) begin
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                        if (stop_q || Stop) begin
                            state_d = StIdle;
                            stop_d  = 1'b0;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end else if (wdog_q == WdogLast) begin
                    state_d = StError;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Pclk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            d_q     <= '0;
            run_q   <= 1'b0;
            count_q <= '0;
            wdog_q  <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            d_q     <= d_d;
            run_q   <= run_d;
            count_q <= count_d;
            wdog_q  <= wdog_d;
            stop_q  <= stop_d;
        end
    end

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign D           = d_q;
    assign Run         = run_q;
    assign instr_count = count_q;
    assign busy        = (state_q == StLoad) || (state_q == StIssue) || (state_q == StWaitDone);
    assign halted      = (state_q == StHalted);
    assign error       = (state_q == StError);

endmodule

// File: tb/tb_scu_sequencer.sv
// Bench for scu_sequencer: ROM model, Done responder and a Run/D scoreboard fed per scenario.
module tb_scu_sequencer;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int PROG_LEN = 4;
    localparam int TIMEOUT  = 64;

    logic              Pclk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic              Stop = 1'b0;
    logic              Done = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] D;
    logic              Run;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              error;
    logic [7:0]        instr_count;

    logic [DATA_W-1:0] rom_mem [16];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_d;
    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;
    int done_delay = 0;
    int done_ctr = 0;
    int run_cnt = 0;
    logic run_prev = 1'b0;

    scu_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PROG_LEN(PROG_LEN),
        .HALT_OP (4'hF),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Pclk       (Pclk),
        .Reset      (Reset),
        .Start      (Start),
        .Stop       (Stop),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .D          (D),
        .Run        (Run),
        .Done       (Done),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .error      (error),
        .instr_count(instr_count)
    );

    always #5 Pclk = ~Pclk;

    always @(posedge Pclk) begin
        rom_data <= rom_mem[rom_addr];
        edge_n   <= edge_n + 1;
    end

    // Scoreboard: every Run pulse pops the next expected instruction word.
    always @(posedge Pclk) begin
        #1;
        if (run_prev) begin
            vectors++;
            if (Run !== 1'b0) begin
                miscompares++;
                $display("FAIL run_width: Run=%b, required 0 one cycle after issue", Run);
            end
        end
        if (Run === 1'b1) begin
            run_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_run: D=%h issued, no issue expected", D);
            end else begin
                exp_d = exp_q.pop_front();
                if (D !== exp_d) begin
                    miscompares++;
                    $display("FAIL issue_word: D=%h, required %h", D, exp_d);
                end
            end
        end
        run_prev = Run;
    end

    initial begin
        #200000;
        $display("FAIL sim_watchdog: time limit reached, required completion");
        $fatal(1);
    end

    // One cycle; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge Pclk);
        @(negedge Pclk);
        if (done_delay > 0) begin
            Done = 1'b0;
            if (done_ctr > 0) begin
                done_ctr--;
                if (done_ctr == 0) Done = 1'b1;
            end
            if (Run === 1'b1) done_ctr = done_delay;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Stop = 1'b0;
        Done = 1'b0;
        done_delay = 0;
        done_ctr = 0;
        exp_q.delete();
        repeat (2) tick();
        Reset = 1'b0;
        run_cnt = 0;
        tick();
    endtask

    task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        for (int i = 0; i < 16; i++) rom_mem[i] = '0;
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        rom_mem[2] = w2;
        rom_mem[3] = w3;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        load_rom(16'h0, 16'h0, 16'h0, 16'h0);
        Reset = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({Run, busy, halted, error} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: Run,busy,halted,error=%b, required 0000",
                     {Run, busy, halted, error});
        end
        vectors++;
        if (D !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_D: D=%h, required 0000", D);
        end
        vectors++;
        if (pc !== 4'h0 || rom_addr !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_pc: pc=%h rom_addr=%h, required 0", pc, rom_addr);
        end
        vectors++;
        if (instr_count !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_count: instr_count=%0d, required 0", instr_count);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_halt_opcode();
        do_reset();
        load_rom(16'h1001, 16'h2002, 16'hF000, 16'h0000);
        exp_q.push_back(16'h1001);
        exp_q.push_back(16'h2002);
        done_delay = 3;
        pulse_start();
        for (int i = 0; i < 100 && halted !== 1'b1; i++) tick();
        vectors++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_state: halted=%b busy=%b, required 1 0", halted, busy);
        end
        vectors++;
        if (run_cnt != 2) begin
            miscompares++;
            $display("FAIL halt_runs: %0d Run pulses, required 2", run_cnt);
        end
        vectors++;
        if (pc !== 4'd2 || D !== 16'hF000) begin
            miscompares++;
            $display("FAIL halt_pc_D: pc=%0d D=%h, required 2 F000", pc, D);
        end
        vectors++;
        if (instr_count !== 8'd2) begin
            miscompares++;
            $display("FAIL halt_count: instr_count=%0d, required 2", instr_count);
        end
    endtask

    task automatic test_latency_and_end();
        do_reset();
        load_rom(16'h1001, 16'h2002, 16'h3003, 16'h4004);
        exp_q.push_back(16'h1001);
        exp_q.push_back(16'h2002);
        exp_q.push_back(16'h3003);
        exp_q.push_back(16'h4004);
        pulse_start();
        tick();
        vectors++;
        if (Run !== 1'b0) begin
            miscompares++;
            $display("FAIL start_latency_early: Run=%b after edge k+1, required 0", Run);
        end
        tick();
        vectors++;
        if (Run !== 1'b1) begin
            miscompares++;
            $display("FAIL start_latency: Run=%b after edge k+2, required 1", Run);
        end
        Done = 1'b1;
        tick();
        Done = 1'b0;
        vectors++;
        if (instr_count !== 8'd0 || pc !== 4'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL done_in_run_cycle: count=%0d pc=%0d busy=%b, required 0 0 1",
                     instr_count, pc, busy);
        end
        tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        vectors++;
        if (instr_count !== 8'd1 || pc !== 4'd1) begin
            miscompares++;
            $display("FAIL done_accept: count=%0d pc=%0d, required 1 1", instr_count, pc);
        end
        tick();
        vectors++;
        if (Run !== 1'b0) begin
            miscompares++;
            $display("FAIL done_latency_early: Run=%b after edge m+1, required 0", Run);
        end
        tick();
        vectors++;
        if (Run !== 1'b1) begin
            miscompares++;
            $display("FAIL done_latency: Run=%b after edge m+2, required 1", Run);
        end
        done_delay = 2;
        done_ctr = 2;
        for (int i = 0; i < 100 && halted !== 1'b1; i++) tick();
        vectors++;
        if (halted !== 1'b1 || pc !== 4'd3) begin
            miscompares++;
            $display("FAIL last_addr: halted=%b pc=%0d, required 1 3", halted, pc);
        end
        vectors++;
        if (instr_count !== 8'd4 || run_cnt != 4) begin
            miscompares++;
            $display("FAIL last_count: count=%0d runs=%0d, required 4 4", instr_count, run_cnt);
        end
    endtask

    task automatic test_timeout();
        int r;
        int e;
        r = -1;
        e = -1;
        do_reset();
        load_rom(16'h1111, 16'h1111, 16'h1111, 16'h1111);
        exp_q.push_back(16'h1111);
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            if (Run === 1'b1) begin
                r = edge_n;
                break;
            end
            tick();
        end
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            tick();
            if (error === 1'b1) begin
                e = edge_n;
                break;
            end
        end
        vectors++;
        if (r < 0 || e < 0 || e - r != TIMEOUT) begin
            miscompares++;
            $display("FAIL timeout_delay: run edge %0d error edge %0d, required gap %0d",
                     r, e, TIMEOUT);
        end
        vectors++;
        if (pc !== 4'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_hold: pc=%0d busy=%b, required 0 0", pc, busy);
        end
        pulse_start();
        vectors++;
        if (error !== 1'b0 || pc !== 4'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_restart: error=%b pc=%0d busy=%b, required 0 0 1",
                     error, pc, busy);
        end
    endtask

    task automatic test_stop();
        do_reset();
        load_rom(16'h1001, 16'h2002, 16'h3003, 16'h4004);
        exp_q.push_back(16'h1001);
        exp_q.push_back(16'h2002);
        done_delay = 3;
        Start = 1'b1;
        Stop = 1'b1;
        tick();
        Start = 1'b0;
        Stop = 1'b0;
        for (int i = 0; i < 60 && run_cnt < 2; i++) tick();
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        repeat (20) tick();
        vectors++;
        if (run_cnt != 2 || pc !== 4'd2) begin
            miscompares++;
            $display("FAIL stop_wait: runs=%0d pc=%0d, required 2 2", run_cnt, pc);
        end
        vectors++;
        if (busy !== 1'b0 || halted !== 1'b0 || error !== 1'b0 || instr_count !== 8'd2) begin
            miscompares++;
            $display("FAIL stop_idle: busy=%b halted=%b error=%b count=%0d, required 0 0 0 2",
                     busy, halted, error, instr_count);
        end
        pulse_start();
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_load: busy=%b, required 0", busy);
        end
        repeat (5) tick();
        vectors++;
        if (run_cnt != 2 || pc !== 4'd0 || instr_count !== 8'd0) begin
            miscompares++;
            $display("FAIL stop_load_quiet: runs=%0d pc=%0d count=%0d, required 2 0 0",
                     run_cnt, pc, instr_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_rom(16'h1001, 16'h2002, 16'h3003, 16'h4004);
        exp_q.push_back(16'h1001);
        exp_q.push_back(16'h2002);
        done_delay = 3;
        pulse_start();
        for (int i = 0; i < 60 && run_cnt < 2; i++) tick();
        #2;
        Reset = 1'b1;
        #1;
        vectors++;
        if (Run !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_run: Run=%b busy=%b, required 0 0", Run, busy);
        end
        vectors++;
        if (D !== 16'h0 || pc !== 4'd0 || instr_count !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset_regs: D=%h pc=%0d count=%0d, required 0 0 0",
                     D, pc, instr_count);
        end
        @(negedge Pclk);
        Reset = 1'b0;
        repeat (8) tick();
        vectors++;
        if (busy !== 1'b0 || instr_count !== 8'd0 || run_cnt != 2) begin
            miscompares++;
            $display("FAIL async_reset_done: busy=%b count=%0d runs=%0d, required 0 0 2",
                     busy, instr_count, run_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_halt_opcode();
        test_latency_and_end();
        test_timeout();
        test_stop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
